store_align_buf: RTL and testbench

STORE_ALIGN_BUF -- requirements
Module: store_align_buf

---
 rtl/store_align_buf_pkg.sv | 32 +++
 rtl/store_align_buf_st_lane_align.sv | 61 ++++++
 rtl/store_align_buf.sv | 147 ++++++++++++++
 tb/tb_store_align_buf.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_align_buf_pkg.sv
// rtl/store_align_buf_pkg.sv - shared store encodings, access sizes and byte-count helpers
// Contents: funct3 store encodings, access_size_e, word_bytes(), access_bytes().
package store_align_buf_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } access_size_e;

    // Bytes in one datapath word (XLEN/8).
    function automatic int word_bytes(input int xlen);
        return xlen / 8;
    endfunction

    // Bytes touched by one access of the given size.
    function automatic int access_bytes(input access_size_e sz);
        case (sz)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/store_align_buf_st_lane_align.sv
// rtl/store_align_buf_st_lane_align.sv - combinational store lane alignment
// Ports: off_i (byte offset in word), data_i (raw rs2), funct3_i (store type),
//        data_o (lane-aligned data), mask_o (byte enables),
//        misalign_o (offset not a multiple of size), illegal_o (undefined or unsupported funct3).
module st_lane_align
    import store_align_buf_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [XLEN-1:0]           data_i,
    input  logic [2:0]                funct3_i,
    output logic [XLEN-1:0]           data_o,
    output logic [XLEN/8-1:0]         mask_o,
    output logic                      misalign_o,
    output logic                      illegal_o
);

    localparam int NB = word_bytes(XLEN);

    access_size_e      size;
    int                nbytes;
    logic [NB-1:0]     base_mask;
    logic [XLEN-1:0]   keep;

    always_comb begin
        size      = SZ_B;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_SB:   size = SZ_B;
            F3_SH:   size = SZ_H;
            F3_SW:   size = SZ_W;
            F3_SD: begin
                size      = SZ_D;
                illegal_o = (XLEN < 64);
            end
            default: illegal_o = 1'b1;
        endcase

        // Clip to the word so an SD on a 32-bit datapath cannot build an oversized mask;
        // such a store is illegal and never reaches the buffer anyway.
        nbytes = access_bytes(size);
        if (nbytes > NB) begin
            nbytes = NB;
        end

        base_mask = '0;
        keep      = '0;
        for (int i = 0; i < NB; i++) begin
            base_mask[i] = (i < nbytes);
            if (i < nbytes) begin
                keep[8*i +: 8] = data_i[8*i +: 8];
            end
        end

        misalign_o = ((int'(off_i) & (nbytes - 1)) != 0);
        data_o     = keep << {off_i, 3'b000};
        mask_o     = base_mask << off_i;
    end

endmodule

// File: rtl/store_align_buf.sv
// rtl/store_align_buf.sv - store alignment front end followed by a registered FIFO write buffer
// Ports: clk_i, rst_ni (async active-low); s_* store request handshake; m_* aligned memory
//        write handshake; misalign_o one-cycle pulse for rejected stores; count_o occupancy.
// Optional macro STORE_FWD_EN adds ld_addr_i / ld_hit_o / ld_fwd_data_o full-word load forwarding.
module store_align_buf
    import store_align_buf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [XLEN-1:0]            s_addr_i,
    input  logic [XLEN-1:0]            s_data_i,
    input  logic [2:0]                 s_funct3_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [XLEN-1:0]            m_addr_o,
    output logic [XLEN-1:0]            m_data_o,
    output logic [XLEN/8-1:0]          m_bmask_o,
    output logic                       misalign_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef STORE_FWD_EN
    ,
    input  logic [XLEN-1:0]            ld_addr_i,
    output logic                       ld_hit_o,
    output logic [XLEN-1:0]            ld_fwd_data_o
`endif
);

    localparam int NB = word_bytes(XLEN);
    localparam int OW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] al_data;
    logic [NB-1:0]   al_mask;
    logic            al_misalign;
    logic            al_illegal;
    logic [XLEN-1:0] al_addr;

    st_lane_align #(.XLEN(XLEN)) u_lane_align (
        .off_i      (s_addr_i[OW-1:0]),
        .data_i     (s_data_i),
        .funct3_i   (s_funct3_i),
        .data_o     (al_data),
        .mask_o     (al_mask),
        .misalign_o (al_misalign),
        .illegal_o  (al_illegal)
    );

    assign al_addr = {s_addr_i[XLEN-1:OW], {OW{1'b0}}};

    logic [XLEN-1:0] addr_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [NB-1:0]   mask_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          misalign_q;

    logic accept;
    logic reject;
    logic push;
    logic pop;

    // s_ready_o depends only on the registered count, so a pop in the same cycle
    // never opens room for a push into a full buffer.
    assign s_ready_o = (count_q < CW'(DEPTH));
    assign accept    = s_valid_i & s_ready_o;
    assign reject    = al_misalign | al_illegal;
    assign push      = accept & ~reject;
    assign m_valid_o = (count_q != '0);
    assign pop       = m_valid_o & m_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept & reject;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= al_addr;
            data_mem[wr_ptr_q] <= al_data;
            mask_mem[wr_ptr_q] <= al_mask;
        end
    end

    assign count_o    = count_q;
    assign misalign_o = misalign_q;
    assign m_addr_o   = m_valid_o ? addr_mem[rd_ptr_q] : '0;
    assign m_data_o   = m_valid_o ? data_mem[rd_ptr_q] : '0;
    assign m_bmask_o  = m_valid_o ? mask_mem[rd_ptr_q] : '0;

`ifdef STORE_FWD_EN
    logic            fwd_found;
    logic [NB-1:0]   fwd_mask;
    logic [XLEN-1:0] fwd_data;
    logic [PW-1:0]   fwd_idx;
    logic [XLEN-1:0] ld_al_addr;
    logic            unused_ld_off;

    assign ld_al_addr    = {ld_addr_i[XLEN-1:OW], {OW{1'b0}}};
    assign unused_ld_off = ^ld_addr_i[OW-1:0];

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_found = 1'b0;
        fwd_mask  = '0;
        fwd_data  = '0;
        fwd_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if ((k < int'(count_q)) && (addr_mem[fwd_idx] == ld_al_addr)) begin
                fwd_found = 1'b1;
                fwd_mask  = mask_mem[fwd_idx];
                fwd_data  = data_mem[fwd_idx];
            end
        end
    end

    assign ld_hit_o      = fwd_found & (&fwd_mask);
    assign ld_fwd_data_o = ld_hit_o ? fwd_data : '0;
`endif

endmodule

// File: tb/tb_store_align_buf.sv
// tb/tb_store_align_buf.sv - scoreboard bench for store_align_buf (XLEN=32, DEPTH=4)
module tb_store_align_buf;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [31:0]     s_addr;
    logic [31:0]     s_data;
    logic [2:0]      s_funct3;
    logic            m_valid;
    logic            m_ready;
    logic [31:0]     m_addr;
    logic [31:0]     m_data;
    logic [3:0]      m_bmask;
    logic            misalign;
    logic [CW-1:0]   count;
`ifdef STORE_FWD_EN
    logic [31:0]     ld_addr;
    logic            ld_hit;
    logic [31:0]     ld_fwd_data;
`endif

    always #5 clk = ~clk;

    store_align_buf #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .s_addr_i      (s_addr),
        .s_data_i      (s_data),
        .s_funct3_i    (s_funct3),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_addr_o      (m_addr),
        .m_data_o      (m_data),
        .m_bmask_o     (m_bmask),
        .misalign_o    (misalign),
        .count_o       (count)
`ifdef STORE_FWD_EN
        ,
        .ld_addr_i     (ld_addr),
        .ld_hit_o      (ld_hit),
        .ld_fwd_data_o (ld_fwd_data)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void exp_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] f, output logic bad, output wr_t e);
        int          off;
        int          sz;
        logic [31:0] keep;
        off = int'(a[1:0]);
        case (f)
            3'b000:  sz = 1;
            3'b001:  sz = 2;
            3'b010:  sz = 4;
            default: sz = 0;
        endcase
        if (sz == 0) begin
            bad = 1'b1;
        end else begin
            bad = ((off % sz) != 0);
        end
        if (sz == 4)      keep = d;
        else if (sz == 2) keep = {16'h0, d[15:0]};
        else              keep = {24'h0, d[7:0]};
        e.addr = {a[31:2], 2'b00};
        e.data = keep << (8 * off);
        e.mask = 4'(((1 << sz) - 1) << off);
    endfunction

    // Scoreboard / protocol monitor, sampling on the falling edge.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [3:0]  prev_mask;
    wr_t         got_e, exp_e;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            check_val("count_le_depth", (count <= DEPTH), 1);
            check_val("valid_eq_nonempty", m_valid, (count != 0));
            if (!m_valid) begin
                check_val("idle_outputs_zero", m_addr | m_data | {28'h0, m_bmask}, 0);
            end
            if (stall_prev && m_valid) begin
                check_val("stall_stable", {m_addr, m_data}, {prev_addr, prev_data});
                check_val("stall_stable_mask", m_bmask, prev_mask);
            end
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected_write", 1, 0);
                end else begin
                    exp_e = sb_q.pop_front();
                    got_e = '{addr: m_addr, data: m_data, mask: m_bmask};
                    check_val("wr_addr", got_e.addr, exp_e.addr);
                    check_val("wr_data", got_e.data, exp_e.data);
                    check_val("wr_mask", got_e.mask, exp_e.mask);
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_addr  = m_addr;
            prev_data  = m_data;
            prev_mask  = m_bmask;
        end
    end

    // Called and returns at posedge+1. Waits for s_ready, scores the store, checks misalign.
    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        logic bad;
        wr_t  e;
        int   waited;
        exp_store(a, d, f, bad, e);
        s_valid  = 1'b1;
        s_addr   = a;
        s_data   = d;
        s_funct3 = f;
        waited   = 0;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            check_val("push_timeout", 0, 1);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
        end else begin
            if (!bad) sb_q.push_back(e);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            check_val("misalign_pulse", misalign, bad);
        end
    endtask

    task automatic drain();
        int w;
        w       = 0;
        m_ready = 1'b1;
        while (count != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_val("drain_done", count, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic bad0;
        wr_t  e0;
        logic [2:0] f;

        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_addr   = '0;
        s_data   = '0;
        s_funct3 = '0;
        m_ready  = 1'b0;
`ifdef STORE_FWD_EN
        ld_addr  = '0;
`endif
        #1;
        check_val("rst_count", count, 0);
        check_val("rst_valid", m_valid, 0);
        check_val("rst_misalign", misalign, 0);
        check_val("rst_ready", s_ready, 1);
        check_val("rst_outputs", m_addr | m_data | {28'h0, m_bmask}, 0);

        // First edge after reset release must accept.
        s_valid  = 1'b1;
        s_addr   = 32'h0000_0100;
        s_data   = 32'h1234_5678;
        s_funct3 = 3'b010;
        exp_store(s_addr, s_data, s_funct3, bad0, e0);
        sb_q.push_back(e0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_val("first_accept_count", count, 1);
        check_val("first_accept_valid", m_valid, 1);
        drain();

        // SB at offset 3.
        push_store(32'h0000_1003, 32'hAABB_CCDD, 3'b000);
        check_val("sb_addr", m_addr, 32'h0000_1000);
        check_val("sb_data", m_data, 32'hDD00_0000);
        check_val("sb_mask", m_bmask, 4'b1000);
        drain();

        // Misaligned SH: handshakes, pulses once, nothing buffered.
        push_store(32'h0000_2001, 32'h0000_BEEF, 3'b001);
        check_val("sh_mis_count", count, 0);
        @(posedge clk);
        #1;
        check_val("sh_mis_pulse_end", misalign, 0);

        // Illegal encodings and another misalignment.
        push_store(32'h0000_2000, 32'hCAFE_F00D, 3'b011);
        push_store(32'h0000_2000, 32'hCAFE_F00D, 3'b101);
        push_store(32'h0000_4002, 32'hCAFE_F00D, 3'b010);
        check_val("illegal_count", count, 0);

        // Legal lane patterns, back to back.
        push_store(32'h0000_0012, 32'h1122_3344, 3'b001);
        push_store(32'h0000_0011, 32'h1122_3344, 3'b000);
        push_store(32'h0000_0010, 32'h1122_3344, 3'b001);
        push_store(32'h0000_0020, 32'h5566_7788, 3'b010);
        drain();

        // Random mix with random backpressure.
        for (int i = 0; i < 30; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 5));
            push_store($urandom, $urandom, f);
        end
        drain();

        // Fill to DEPTH, hold off a fifth store.
        for (int i = 0; i < 4; i++) begin
            push_store(32'h0000_5000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010);
        end
        check_val("full_ready", s_ready, 0);
        check_val("full_count", count, DEPTH);
        s_valid  = 1'b1;
        s_addr   = 32'h0000_5010;
        s_data   = 32'hA000_0004;
        s_funct3 = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("held_count", count, DEPTH);
            check_val("held_ready", s_ready, 0);
        end
        s_valid = 1'b0;

        // Drain while pushing every cycle; pointers wrap.
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_store(32'h0000_5010 + 32'(4 * i), 32'hA000_0004 + 32'(i), 3'b010);
        end
        drain();

        // Reset with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            push_store(32'h0000_6000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 3'b010);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_count", count, 0);
        check_val("mid_rst_valid", m_valid, 0);
        check_val("mid_rst_outputs", m_addr | m_data | {28'h0, m_bmask}, 0);
        sb_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_store(32'h0000_7000, 32'hC0DE_0001, 3'b010);
        check_val("post_rst_count", count, 1);
        drain();

`ifdef STORE_FWD_EN
        push_store(32'h0000_3000, 32'h1111_1111, 3'b010);
        push_store(32'h0000_3000, 32'h2222_2222, 3'b010);
        ld_addr = 32'h0000_3000;
        #1;
        check_val("fwd_hit", ld_hit, 1);
        check_val("fwd_data", ld_fwd_data, 32'h2222_2222);
        ld_addr = 32'h0000_4000;
        #1;
        check_val("fwd_miss_hit", ld_hit, 0);
        check_val("fwd_miss_data", ld_fwd_data, 0);
        push_store(32'h0000_3001, 32'h0000_0033, 3'b000);
        ld_addr = 32'h0000_3000;
        #1;
        check_val("fwd_partial_hit", ld_hit, 0);
        check_val("fwd_partial_data", ld_fwd_data, 0);
        drain();
`endif

        repeat (2) @(posedge clk);
        #1;
        check_val("sb_empty_end", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
